imem_loader: RTL and testbench

Writer side of the instruction-memory path: receives a program image as a byte stream and writes 16-bit instruction words into one write-enabled port of the dual-port instruction RAM. The two CPU cores only ever read that RAM. While loading, the block holds both cores in reset through `cpu_hold`, and releases them only after the image passes its checksum. It sits in the top level between an external byte source (UART receiver or debug bridge) and the IMEM write port.

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader.sv | 132 +++++++++++++
 tb/tb_imem_loader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// No logic, so no latency.
// No handshake of its own.
package loader_pkg;

  // Loader FSM states; the encoding is visible on the state register
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    CHECK   = 3'd5,
    DONE    = 3'd6,
    ERR     = 3'd7
  } loader_state_t;

  // Starting value of the running XOR over the image bytes
  localparam logic [7:0] CKSUM_SEED = 8'h00;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and IMEM write-port bundles for the loader.
// Wires only, so no latency.
// byte_if uses valid/ready: a byte moves when in_valid && in_ready.

// Byte stream: master is the byte source, slave is the loader
interface byte_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// IMEM write port: master is the loader, slave is the RAM
interface imem_wr_if #(
  parameter int ADDR_W = 8
);
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [15:0]       im_wdata;

  modport master (output im_we, output im_addr, output im_wdata);
  modport slave  (input im_we, input im_addr, input im_wdata);
endinterface

// File: rtl/imem_loader.sv
// Parses a length-prefixed, XOR-checked byte image into 16-bit IMEM writes and holds the CPUs until it verifies.
// Latency: im_we one cycle after the low-byte accept; done/err one cycle after the checksum accept.
// Backpressure: in_ready is a pure state decode; gaps in in_valid only stretch the load.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  byte_if.slave     in_if,
  imem_wr_if.master im_if,
  output logic      cpu_hold,
  output logic      done,
  output logic      err
);

  localparam logic [2:0]  S_IDLE    = IDLE;
  localparam logic [2:0]  S_LEN_HI  = LEN_HI;
  localparam logic [2:0]  S_LEN_LO  = LEN_LO;
  localparam logic [2:0]  S_DATA_HI = DATA_HI;
  localparam logic [2:0]  S_DATA_LO = DATA_LO;
  localparam logic [2:0]  S_CHECK   = CHECK;
  localparam logic [2:0]  S_DONE    = DONE;
  localparam logic [2:0]  S_ERR     = ERR;
  // One bit wider than the length field so DEPTH = 65536 still compares correctly
  localparam logic [16:0] LP_DEPTH  = 17'(DEPTH);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [7:0]        r_xor;
  logic [15:0]       r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;

  logic              w_ready;
  logic              w_accept;
  logic              w_start_ok;
  logic [15:0]       w_len;
  logic              w_len_big;

  // Ready is decoded from the state alone, never from in_valid
  assign w_ready    = (r_state == S_LEN_HI)  || (r_state == S_LEN_LO) ||
                      (r_state == S_DATA_HI) || (r_state == S_DATA_LO) ||
                      (r_state == S_CHECK);
  assign w_accept   = in_if.in_valid && w_ready;
  // start only counts when no load is in progress
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
  // High length byte is parked in the top of the counter until the low byte arrives
  assign w_len      = {r_cnt[15:8], in_if.in_data};
  assign w_len_big  = {1'b0, w_len} > LP_DEPTH;

  // Next-state decode of the image format
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_LEN_HI;
      S_LEN_HI:  if (w_accept) w_state_nxt = S_LEN_LO;
      S_LEN_LO:
        if (w_accept) begin
          if (w_len_big)           w_state_nxt = S_ERR;
          else if (w_len == 16'd0) w_state_nxt = S_CHECK;
          else                     w_state_nxt = S_DATA_HI;
        end
      S_DATA_HI: if (w_accept) w_state_nxt = S_DATA_LO;
      S_DATA_LO: if (w_accept) w_state_nxt = (r_cnt == 16'd1) ? S_CHECK : S_DATA_HI;
      S_CHECK:   if (w_accept) w_state_nxt = (in_if.in_data == r_xor) ? S_DONE : S_ERR;
      S_DONE:    if (start) w_state_nxt = S_LEN_HI;
      S_ERR:     if (start) w_state_nxt = S_LEN_HI;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Running XOR over every byte before the checksum byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               r_xor <= CKSUM_SEED;
    else if (w_start_ok)                   r_xor <= CKSUM_SEED;
    else if (w_accept && r_state != S_CHECK) r_xor <= r_xor ^ in_if.in_data;
  end

  // Remaining-word counter: length captured, then counted down per word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 16'd0;
    end else if (w_accept) begin
      if (r_state == S_LEN_HI)       r_cnt[15:8] <= in_if.in_data;
      else if (r_state == S_LEN_LO)  r_cnt <= w_len;
      else if (r_state == S_DATA_LO) r_cnt <= r_cnt - 16'd1;
    end
  end

  // Word assembly, big-endian: high byte first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdata <= 16'd0;
    end else if (w_accept) begin
      if (r_state == S_DATA_HI)      r_wdata[15:8] <= in_if.in_data;
      else if (r_state == S_DATA_LO) r_wdata[7:0]  <= in_if.in_data;
    end
  end

  // One-cycle write strobe after the low byte lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_we <= 1'b0;
    else     r_we <= w_accept && (r_state == S_DATA_LO);
  end

  // Address holds through the strobe cycle and steps right after it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_addr <= '0;
    else if (w_start_ok) r_addr <= '0;
    else if (r_we)       r_addr <= r_addr + ADDR_W'(1);
  end

  assign in_if.in_ready = w_ready;
  assign im_if.im_we    = r_we;
  assign im_if.im_addr  = r_addr;
  assign im_if.im_wdata = r_wdata;
  assign cpu_hold       = (r_state != S_DONE);
  assign done           = (r_state == S_DONE);
  assign err            = (r_state == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader with a byte-image reference model.
// Model works on whole images: parse length, list expected writes, XOR for status.
// Scenario tasks run in sequence from one initial block.
module tb_imem_loader;

  localparam int AW    = 8;
  localparam int DEPTH = 256;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic cpu_hold, done, err;

  byte_if                  src_if();
  imem_wr_if #(.ADDR_W(AW)) im_if();

  imem_loader #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_if    (src_if),
    .im_if    (im_if),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [AW+15:0] wr_q[$];
  int             wr_t[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every write seen by the RAM, sampled mid-cycle
  always @(negedge clk) begin
    if (im_if.im_we === 1'b1) begin
      wr_q.push_back({im_if.im_addr, im_if.im_wdata});
      wr_t.push_back(cyc);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // All tasks are entered and left on a falling edge
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      src_if.in_valid = 1'b0;
      @(negedge clk);
    end
    src_if.in_valid = 1'b1;
    src_if.in_data  = b;
    t = 0;
    while (src_if.in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 50) begin
      errors++;
      $display("FAIL send_timeout: byte %02h got in_ready=%b, required 1 within 50 cycles", b, src_if.in_ready);
    end
    @(negedge clk);
    src_if.in_valid = 1'b0;
  endtask

  // Builds a well-formed image of n random words, optionally with a corrupted checksum
  task automatic build_image(input int n, input bit corrupt, output bq_t img);
    logic [7:0] x;
    img = {};
    img.push_back(8'(n >> 8));
    img.push_back(8'(n));
    for (int i = 0; i < 2 * n; i++) img.push_back(8'($urandom));
    x = 8'h00;
    foreach (img[k]) x ^= img[k];
    if (corrupt) x ^= 8'($urandom_range(1, 255));
    img.push_back(x);
  endtask

  // Runs one load and compares the outcome with the image-level model
  task automatic run_load(input string name, input bq_t img, input int max_gap);
    int n, consumed;
    logic [7:0] x;
    bit exp_done, exp_err;
    logic [AW+15:0] exp_q[$];
    n = {img[0], img[1]};
    exp_q = {};
    if (n > DEPTH) begin
      consumed = 2; exp_done = 0; exp_err = 1;
    end else begin
      for (int i = 0; i < n; i++) exp_q.push_back({AW'(i), img[2+2*i], img[3+2*i]});
      x = 8'h00;
      for (int k = 0; k < 2 * n + 2; k++) x ^= img[k];
      consumed = 2 * n + 3;
      exp_done = (img[2*n+2] == x);
      exp_err  = !exp_done;
    end
    pulse_start();
    wr_q.delete();
    wr_t.delete();
    for (int i = 0; i < consumed; i++) send_byte(img[i], $urandom_range(0, max_gap));
    checks++;
    if (done !== exp_done || err !== exp_err) begin
      errors++;
      $display("FAIL %s_status: done=%b err=%b, required done=%b err=%b", name, done, err, exp_done, exp_err);
    end
    checks++;
    if (cpu_hold !== !exp_done) begin
      errors++;
      $display("FAIL %s_cpu_hold: got %b, required %b", name, cpu_hold, !exp_done);
    end
    checks++;
    if (src_if.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_in_ready: got %b, required 0", name, src_if.in_ready);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_write_count: got %0d, required %0d", name, wr_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (wr_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s_write[%0d]: got addr/data %h, required %h", name, i, wr_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({im_if.im_we, im_if.im_addr, im_if.im_wdata, cpu_hold, done, err, src_if.in_ready} !==
        {1'b0, AW'(0), 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s: we=%b addr=%h wdata=%h hold=%b done=%b err=%b rdy=%b, required 0 00 0000 1 0 0 0",
               name, im_if.im_we, im_if.im_addr, im_if.im_wdata, cpu_hold, done, err, src_if.in_ready);
    end
  endtask

  task automatic test_reset();
    #3;
    check_reset_outputs("reset_async");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_nominal();
    bq_t img;
    img = {8'h00, 8'h02, 8'hA5, 8'hC3, 8'h12, 8'h34, 8'h42};
    run_load("nominal", img, 0);
    checks++;
    if (wr_q.size() != 2 || wr_q[0] !== 24'h00A5C3 || wr_q[1] !== 24'h011234) begin
      errors++;
      $display("FAIL nominal_literal: got %0d writes, first=%h second=%h, required 00A5C3 011234",
               wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 24'h0, (wr_q.size() > 1) ? wr_q[1] : 24'h0);
    end
    checks++;
    if (wr_t.size() != 2 || wr_t[1] - wr_t[0] != 2) begin
      errors++;
      $display("FAIL nominal_spacing: got %0d writes, gap=%0d, required 2 writes 2 cycles apart",
               wr_t.size(), (wr_t.size() > 1) ? wr_t[1] - wr_t[0] : -1);
    end
  endtask

  task automatic test_empty();
    bq_t img;
    img = {8'h00, 8'h00, 8'h00};
    run_load("empty", img, 0);
  endtask

  task automatic test_too_large();
    bq_t img;
    img = {8'h01, 8'h01};
    run_load("too_large", img, 0);
  endtask

  task automatic test_bad_cksum();
    bq_t img;
    img = {8'h00, 8'h02, 8'hA5, 8'hC3, 8'h12, 8'h34, 8'h43};
    run_load("bad_cksum", img, 0);
  endtask

  task automatic test_reset_midload();
    bq_t img;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hA5, 0);
    send_byte(8'hC3, 0);
    send_byte(8'h12, 0);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midload_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    img = {8'h00, 8'h02, 8'hA5, 8'hC3, 8'h12, 8'h34, 8'h42};
    run_load("after_reset", img, 0);
  endtask

  task automatic test_backpressure_restart();
    bq_t img;
    img = {8'h00, 8'h02, 8'hA5, 8'hC3, 8'h12, 8'h34, 8'h42};
    run_load("backpressure", img, 3);
    pulse_start();
    checks++;
    if (cpu_hold !== 1'b1 || done !== 1'b0 || src_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart: hold=%b done=%b rdy=%b, required 1 0 1", cpu_hold, done, src_if.in_ready);
    end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL restart_empty_done: got %b, required 1", done);
    end
  endtask

  task automatic test_start_ignored();
    pulse_start();
    wr_q.delete();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    start = 1'b1;
    send_byte(8'hBE, 0);
    start = 1'b0;
    send_byte(8'hEF, 0);
    send_byte(8'h50, 0);
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored_status: done=%b err=%b, required 1 0", done, err);
    end
    @(negedge clk);
    checks++;
    if (wr_q.size() != 1 || wr_q[0] !== 24'h00BEEF) begin
      errors++;
      $display("FAIL start_ignored_write: got %0d writes first=%h, required 1 write 00BEEF",
               wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 24'h0);
    end
  endtask

  task automatic test_boundary();
    bq_t img;
    build_image(DEPTH, 1'b0, img);
    run_load("depth_full", img, 0);
    img = {8'h01, 8'h00, 8'h00};
    img[0] = 8'((DEPTH + 1) >> 8);
    img[1] = 8'(DEPTH + 1);
    run_load("depth_plus_one", img, 0);
  endtask

  task automatic test_random();
    bq_t img;
    int n;
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 5) == 0) n = $urandom_range(DEPTH + 1, 65535);
      else                           n = $urandom_range(0, 20);
      build_image(n, $urandom_range(0, 2) == 0, img);
      run_load($sformatf("random%0d", it), img, $urandom_range(0, 1) * 3);
    end
  endtask

  initial begin
    src_if.in_valid = 1'b0;
    src_if.in_data  = 8'h00;
    test_reset();
    test_nominal();
    test_empty();
    test_too_large();
    test_bad_cksum();
    test_reset_midload();
    test_backpressure_restart();
    test_start_ignored();
    test_boundary();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
